// File: rtl/ctrl_pipe_param.sv
// ctrl_pipe_param: valid-tracked D/E/M*/W control pipeline with E stall, flush priority and retire counter
module ctrl_pipe_param #(
  parameter int CTRLW      = 8,
  parameter int RSW        = 3,
  parameter int MEM_STAGES = 1,
  parameter int CNTW       = 32,
  parameter int LOAD_RS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic [RSW-1:0]   ResultSrcD,
  input  logic [CTRLW-1:0] CtrlD,
  output logic             ValidE,
  output logic [CTRLW-1:0] CtrlE,
  output logic [RSW-1:0]   ResultSrcE,
  output logic             LoadE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [RSW-1:0]   ResultSrcM,
  output logic             RegWriteW,
  output logic [RSW-1:0]   ResultSrcW,
  output logic             ValidW,
  output logic [CNTW-1:0]  RetireCnt
);
  localparam int L = MEM_STAGES - 1;
  if (MEM_STAGES < 1 || MEM_STAGES > 4) begin : g_bad_mem_stages
    $error("MEM_STAGES must be 1..4");
  end
  logic                  rw_e, mw_e, rw_w;
  logic [MEM_STAGES-1:0] valid_m, rw_m, mw_m;
  logic [RSW-1:0]        rs_m [MEM_STAGES];
  always_ff @(posedge clk) begin
    if (reset) begin
      ValidE     <= 1'b0;
      rw_e       <= 1'b0;
      mw_e       <= 1'b0;
      CtrlE      <= '0;
      ResultSrcE <= '0;
      valid_m    <= '0;
      rw_m       <= '0;
      mw_m       <= '0;
      rs_m       <= '{default: '0};
      ValidW     <= 1'b0;
      rw_w       <= 1'b0;
      ResultSrcW <= '0;
      RetireCnt  <= '0;
    end else begin
      ValidE     <= !FlushE && (StallE ? ValidE : ValidD);
      rw_e       <= !FlushE && (StallE ? rw_e : ValidD && RegWriteD);
      mw_e       <= !FlushE && (StallE ? mw_e : ValidD && MemWriteD);
      CtrlE      <= FlushE ? '0 : StallE ? CtrlE : ValidD ? CtrlD : '0;
      ResultSrcE <= FlushE ? '0 : StallE ? ResultSrcE : ValidD ? ResultSrcD : '0;
      valid_m[0] <= !StallE && ValidE;
      rw_m[0]    <= !StallE && rw_e;
      mw_m[0]    <= !StallE && mw_e;
      rs_m[0]    <= StallE ? '0 : ResultSrcE;
      for (int i = 1; i < MEM_STAGES; i++) begin
        valid_m[i] <= valid_m[i-1];
        rw_m[i]    <= rw_m[i-1];
        mw_m[i]    <= mw_m[i-1];
        rs_m[i]    <= rs_m[i-1];
      end
      ValidW     <= valid_m[L];
      rw_w       <= rw_m[L];
      ResultSrcW <= rs_m[L];
      RetireCnt  <= RetireCnt + CNTW'(ValidW);
    end
  end
  assign LoadE      = ValidE && (ResultSrcE == RSW'(LOAD_RS));
  assign RegWriteM  = valid_m[L] && rw_m[L];
  assign MemWriteM  = valid_m[L] && mw_m[L];
  assign ResultSrcM = rs_m[L];
  assign RegWriteW  = ValidW && rw_w;
endmodule

// File: tb/tb_ctrl_pipe_param.sv
// tb_ctrl_pipe_param: table vectors plus retire scoreboard for two ctrl_pipe_param configurations
module tb_ctrl_pipe_param;
  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mw;
    logic [2:0] rs;
    logic [7:0] ctrl;
  } instr_t;
  typedef struct {
    instr_t     d;
    logic       st;
    logic       fl;
    logic       ve;
    logic [7:0] ce;
    logic [2:0] rse;
    logic       le;
    logic       rwm;
    logic       mwm;
    logic [2:0] rsm;
  } vec_t;
  logic clk = 1'b0;
  logic reset, StallE, FlushE, ValidD, RegWriteD, MemWriteD;
  logic [2:0] ResultSrcD;
  logic [7:0] CtrlD;
  logic       ValidE1, LoadE1, RegWriteM1, MemWriteM1, RegWriteW1, ValidW1;
  logic [7:0] CtrlE1;
  logic [2:0] ResultSrcE1, ResultSrcM1, ResultSrcW1;
  logic [31:0] RetireCnt1;
  logic       ValidE3, LoadE3, RegWriteM3, MemWriteM3, RegWriteW3, ValidW3;
  logic [7:0] CtrlE3;
  logic [2:0] ResultSrcE3, ResultSrcM3, ResultSrcW3;
  logic [3:0] RetireCnt3;
  instr_t q1[$], q3[$];
  instr_t e_m, exp_i;
  vec_t   tv[12];
  int     vectors = 0, miscompares = 0, n_push = 0;
  always #5 clk = ~clk;
  ctrl_pipe_param #(.CTRLW(8), .RSW(3), .MEM_STAGES(1), .CNTW(32), .LOAD_RS(1)) dut1 (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .CtrlD(CtrlD),
    .ValidE(ValidE1), .CtrlE(CtrlE1), .ResultSrcE(ResultSrcE1), .LoadE(LoadE1),
    .RegWriteM(RegWriteM1), .MemWriteM(MemWriteM1), .ResultSrcM(ResultSrcM1),
    .RegWriteW(RegWriteW1), .ResultSrcW(ResultSrcW1), .ValidW(ValidW1), .RetireCnt(RetireCnt1)
  );
  ctrl_pipe_param #(.CTRLW(8), .RSW(3), .MEM_STAGES(3), .CNTW(4), .LOAD_RS(1)) dut3 (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .CtrlD(CtrlD),
    .ValidE(ValidE3), .CtrlE(CtrlE3), .ResultSrcE(ResultSrcE3), .LoadE(LoadE3),
    .RegWriteM(RegWriteM3), .MemWriteM(MemWriteM3), .ResultSrcM(ResultSrcM3),
    .RegWriteW(RegWriteW3), .ResultSrcW(ResultSrcW3), .ValidW(ValidW3), .RetireCnt(RetireCnt3)
  );
  function automatic instr_t ins(logic v, logic rw, logic mw, logic [2:0] rs, logic [7:0] c);
    return {v, rw, mw, rs, c};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask
  task automatic check_w();
    if (ValidW1) begin
      if (q1.size() == 0) chk("retire1_unexpected", {1'b1, RegWriteW1, ResultSrcW1}, 0);
      else begin
        exp_i = q1.pop_front();
        chk("retire1", {RegWriteW1, ResultSrcW1}, {exp_i.rw, exp_i.rs});
      end
    end
    if (ValidW3) begin
      if (q3.size() == 0) chk("retire3_unexpected", {1'b1, RegWriteW3, ResultSrcW3}, 0);
      else begin
        exp_i = q3.pop_front();
        chk("retire3", {RegWriteW3, ResultSrcW3}, {exp_i.rw, exp_i.rs});
      end
    end
  endtask
  task automatic drive(instr_t d, logic st, logic fl, logic r);
    ValidD = d.v;
    RegWriteD = d.rw;
    MemWriteD = d.mw;
    ResultSrcD = d.rs;
    CtrlD = d.ctrl;
    StallE = st;
    FlushE = fl;
    reset = r;
    @(posedge clk);
    if (r) begin
      q1.delete();
      q3.delete();
      e_m = '0;
      n_push = 0;
    end else begin
      if (!st && e_m.v) begin
        q1.push_back(e_m);
        q3.push_back(e_m);
        n_push++;
      end
      e_m = fl ? '0 : st ? e_m : d.v ? d : '0;
    end
    #4;
    check_w();
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic chk_zero(string name);
    chk({name, "_d1"}, {ValidE1, CtrlE1, ResultSrcE1, LoadE1, RegWriteM1, MemWriteM1, ResultSrcM1,
                        RegWriteW1, ResultSrcW1, ValidW1, RetireCnt1}, 0);
    chk({name, "_d3"}, {ValidE3, CtrlE3, ResultSrcE3, LoadE3, RegWriteM3, MemWriteM3, ResultSrcM3,
                        RegWriteW3, ResultSrcW3, ValidW3, RetireCnt3}, 0);
  endtask
  initial begin
    tv[0]  = '{ins(1'b1, 1'b1, 1'b0, 3'd2, 8'hA1), 1'b0, 1'b0, 1'b1, 8'hA1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[1]  = '{ins(1'b1, 1'b0, 1'b1, 3'd1, 8'hB2), 1'b0, 1'b0, 1'b1, 8'hB2, 3'd1, 1'b1, 1'b1, 1'b0, 3'd2};
    tv[2]  = '{ins(1'b0, 1'b1, 1'b1, 3'd3, 8'hFF), 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1};
    tv[3]  = '{ins(1'b1, 1'b1, 1'b1, 3'd1, 8'hC3), 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[4]  = '{ins(1'b1, 1'b1, 1'b0, 3'd4, 8'hD4), 1'b0, 1'b0, 1'b1, 8'hD4, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[5]  = '{ins(1'b1, 1'b0, 1'b0, 3'd5, 8'hE5), 1'b1, 1'b0, 1'b1, 8'hD4, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[6]  = '{ins(1'b1, 1'b0, 1'b0, 3'd5, 8'hE5), 1'b1, 1'b0, 1'b1, 8'hD4, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[7]  = '{ins(1'b1, 1'b0, 1'b1, 3'd1, 8'h66), 1'b0, 1'b0, 1'b1, 8'h66, 3'd1, 1'b1, 1'b1, 1'b0, 3'd4};
    tv[8]  = '{ins(1'b1, 1'b1, 1'b0, 3'd2, 8'h77), 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[9]  = '{ins(1'b1, 1'b1, 1'b1, 3'd7, 8'h88), 1'b0, 1'b0, 1'b1, 8'h88, 3'd7, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[10] = '{ins(1'b0, 1'b0, 1'b0, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 3'd7};
    tv[11] = '{ins(1'b0, 1'b0, 1'b0, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    e_m = '0;
    drive('0, 1'b0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b1);
    chk_zero("reset");
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].d, tv[i].st, tv[i].fl, 1'b0);
      chk($sformatf("row%0d_d1", i),
          {ValidE1, CtrlE1, ResultSrcE1, LoadE1, RegWriteM1, MemWriteM1, ResultSrcM1},
          {tv[i].ve, tv[i].ce, tv[i].rse, tv[i].le, tv[i].rwm, tv[i].mwm, tv[i].rsm});
      chk($sformatf("row%0d_e3", i), {ValidE3, CtrlE3, ResultSrcE3, LoadE3},
          {tv[i].ve, tv[i].ce, tv[i].rse, tv[i].le});
    end
    idle(6);
    chk("table_drain", q1.size() + q3.size(), 0);
    chk("table_cnt1", RetireCnt1, 4);
    chk("table_cnt3", RetireCnt3, 4);
    drive('0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      drive(k == 1 ? ins(1'b1, 1'b1, 1'b0, 3'd2, 8'h5A) : '0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("lat_d1_c%0d", k),
          {ValidE1, RegWriteM1, ResultSrcM1, RegWriteW1, ValidW1, RetireCnt1},
          {k == 1, k == 2, k == 2 ? 3'd2 : 3'd0, k == 3, k == 3, 32'(k >= 4)});
      chk($sformatf("lat_d3_c%0d", k), {ValidW3, RegWriteW3, RetireCnt3},
          {k == 5, k == 5, 4'(k >= 6)});
    end
    drive('0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      drive(k == 1 ? ins(1'b1, 1'b1, 1'b0, 3'd3, 8'h9C) :
            (k <= 3 ? ins(1'b1, 1'b0, 1'b0, 3'd6, 8'h11) : '0), k == 2 || k == 3, 1'b0, 1'b0);
      chk($sformatf("stall_c%0d", k), {ValidW1, RegWriteM1, ValidW3}, {k == 5, k == 4, k == 7});
      if (k <= 3) chk($sformatf("stall_hold_c%0d", k), {ValidE1, CtrlE1}, {1'b1, 8'h9C});
    end
    idle(3);
    chk("stall_cnt1", RetireCnt1, 1);
    chk("stall_cnt3", RetireCnt3, 1);
    drive('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(ins(1'b1, 1'b1, 1'b1, 3'(i + 1), 8'(8'h30 + i)), 1'b0, 1'b0, 1'b0);
    drive(ins(1'b1, 1'b1, 1'b1, 3'd4, 8'h44), 1'b0, 1'b0, 1'b1);
    chk_zero("reset_mid");
    idle(6);
    chk("reset_mid_cnt", {RetireCnt1, RetireCnt3}, 0);
    for (int i = 0; i < 17; i++) drive(ins(1'b1, 1'b1, 1'b0, 3'(i), 8'(i)), 1'b0, 1'b0, 1'b0);
    idle(8);
    chk("wrap_cnt3", RetireCnt3, 1);
    chk("wrap_cnt1", RetireCnt1, 17);
    chk("wrap_drain", q1.size() + q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
